// File: rtl/key_insn_encoder_if.sv
// Game-input instruction bus from the push-button encoder to the processor core.
interface key_insn_encoder_if;
    logic [31:0] insn_key;
    logic        key_pressed;
    logic [2:0]  key_state;

    modport master (
        output insn_key,
        output key_pressed,
        output key_state
    );

    modport slave (
        input insn_key,
        input key_pressed,
        input key_state
    );
endinterface

// File: rtl/key_insn_encoder.sv
// Turns the three active-low DE2 push-buttons into debounced, auto-repeating game instructions.
// Key bit order everywhere is {left (KEY3), right (KEY2), fire (KEY1)}.
module key_insn_encoder #(
    parameter int unsigned DB_CYCLES     = 35000,
    parameter int unsigned DB_W          = 16,
    parameter int unsigned REPEAT_DELAY  = 1750000,
    parameter int unsigned REPEAT_PERIOD = 350000,
    parameter int unsigned RPT_W         = 21,
    parameter logic [31:0] INSN_LEFT     = 32'h0000_0001,
    parameter logic [31:0] INSN_RIGHT    = 32'h0000_0002,
    parameter logic [31:0] INSN_FIRE     = 32'h0000_0003
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               KEY3,
    input  logic               KEY2,
    input  logic               KEY1,
    key_insn_encoder_if.master key_bus
);

    localparam logic [DB_W-1:0]  DbLast     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RptDelay   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RptPeriod  = RPT_W'(REPEAT_PERIOD - 1);

    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            lvl;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            state_q, state_d;
    logic [2:0]            press;
    // Repeat timers exist only for the move keys: index 0 = right, 1 = left.
    logic [1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]            rpt_evt;
    logic [2:0]            event_set;
    logic [2:0]            pending_q, pending_d;
    logic [2:0]            grant;
    logic [31:0]           insn_q, insn_d;
    logic                  pressed_q, pressed_d;

    assign lvl = ~sync2_q;

    always_comb begin
        state_d  = state_q;
        db_cnt_d = '0;
        for (int k = 0; k < 3; k++) begin
            if (lvl[k] != state_q[k]) begin
                if (db_cnt_q[k] == DbLast) begin
                    state_d[k] = ~state_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign press = state_d & ~state_q;

    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_evt   = '0;
        for (int r = 0; r < 2; r++) begin
            if (press[r+1]) begin
                rpt_cnt_d[r] = RptDelay;
            end else if (state_q[r+1] && state_d[r+1]) begin
                // Only a key that stays held this cycle may repeat; a releasing key is silent.
                if (rpt_cnt_q[r] == '0) begin
                    rpt_evt[r]   = 1'b1;
                    rpt_cnt_d[r] = RptPeriod;
                end else begin
                    rpt_cnt_d[r] = rpt_cnt_q[r] - 1'b1;
                end
            end else begin
                rpt_cnt_d[r] = '0;
            end
        end
    end

    assign event_set = press | {rpt_evt, 1'b0};

    always_comb begin
        grant     = 3'b000;
        insn_d    = insn_q;
        pressed_d = 1'b0;
        if (pending_q[0]) begin
            grant     = 3'b001;
            insn_d    = INSN_FIRE;
            pressed_d = 1'b1;
        end else if (pending_q[2]) begin
            grant     = 3'b100;
            insn_d    = INSN_LEFT;
            pressed_d = 1'b1;
        end else if (pending_q[1]) begin
            grant     = 3'b010;
            insn_d    = INSN_RIGHT;
            pressed_d = 1'b1;
        end
    end

    // A fresh event on the bit being issued keeps it pending.
    assign pending_d = (pending_q & ~grant) | event_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            db_cnt_q  <= '0;
            state_q   <= '0;
            rpt_cnt_q <= '0;
            pending_q <= '0;
            insn_q    <= '0;
            pressed_q <= 1'b0;
        end else begin
            sync1_q   <= {KEY3, KEY2, KEY1};
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pending_q <= pending_d;
            insn_q    <= insn_d;
            pressed_q <= pressed_d;
        end
    end

    assign key_bus.insn_key    = insn_q;
    assign key_bus.key_pressed = pressed_q;
    assign key_bus.key_state   = state_q;

endmodule

// File: tb/tb_key_insn_encoder.sv
// Directed bench for key_insn_encoder with short debounce and repeat timings.
module tb_key_insn_encoder;

    logic clk = 1'b0;
    logic reset;
    logic KEY3, KEY2, KEY1;

    key_insn_encoder_if bus ();

    key_insn_encoder #(
        .DB_CYCLES    (4),
        .DB_W         (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(5),
        .RPT_W        (5),
        .INSN_LEFT    (32'h0000_0001),
        .INSN_RIGHT   (32'h0000_0002),
        .INSN_FIRE    (32'h0000_0003)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .KEY3   (KEY3),
        .KEY2   (KEY2),
        .KEY1   (KEY1),
        .key_bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic        got_p [0:63];
    logic [31:0] got_i [0:63];

    // Advance past the next rising edge and land on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        KEY3 = 1'b1;
        KEY2 = 1'b1;
        KEY1 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        KEY3 = 1'b1;
        KEY2 = 1'b1;
        KEY1 = 1'b1;
        #12;
        checks++;
        if ({bus.insn_key, bus.key_pressed, bus.key_state} !== 36'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.insn_key, bus.key_pressed, bus.key_state});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.key_pressed !== 1'b0 || bus.key_state !== 3'b000)
                $display("FAIL idle_after_reset cyc %0d: pressed %b state %b required 0/000",
                         i, bus.key_pressed, bus.key_state);
            else passes++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            KEY1 = (i < 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (bus.key_pressed !== 1'b0 || bus.key_state !== 3'b000)
                $display("FAIL glitch cyc %0d: pressed %b state %b required 0/000",
                         i, bus.key_pressed, bus.key_state);
            else passes++;
        end
    endtask

    task automatic test_fire_single();
        int n_strobe;
        int at;
        do_reset();
        n_strobe = 0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            KEY1 = 1'b0;
            step();
            if (bus.key_pressed === 1'b1) begin
                n_strobe++;
                at = i;
                checks++;
                if (bus.insn_key !== 32'h3)
                    $display("FAIL fire_insn: got %h required 00000003", bus.insn_key);
                else passes++;
            end
        end
        checks++;
        if (n_strobe !== 1) $display("FAIL fire_count: got %0d required 1", n_strobe);
        else passes++;
        checks++;
        if (at !== 6) $display("FAIL fire_latency: got edge %0d required 6", at);
        else passes++;
        checks++;
        if (bus.key_state !== 3'b001) $display("FAIL fire_state: got %b required 001", bus.key_state);
        else passes++;
        checks++;
        if (bus.insn_key !== 32'h3) $display("FAIL fire_hold: got %h required 00000003", bus.insn_key);
        else passes++;
        KEY1 = 1'b1;
        repeat (10) step();
        checks++;
        if (bus.key_state !== 3'b000) $display("FAIL fire_release: got %b required 000", bus.key_state);
        else passes++;
    endtask

    task automatic test_left_repeat();
        logic exp;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            KEY3 = (i < 40) ? 1'b0 : 1'b1;
            step();
            got_p[i] = bus.key_pressed;
            got_i[i] = bus.insn_key;
        end
        for (int i = 0; i < 40; i++) begin
            exp = (i == 6 || i == 16 || i == 21 || i == 26 || i == 31 || i == 36);
            checks++;
            if (got_p[i] !== exp)
                $display("FAIL left_repeat edge %0d: pressed %b required %b", i, got_p[i], exp);
            else passes++;
            if (exp) begin
                checks++;
                if (got_i[i] !== 32'h1)
                    $display("FAIL left_insn edge %0d: got %h required 00000001", i, got_i[i]);
                else passes++;
            end
        end
        for (int i = 47; i < 60; i++) begin
            checks++;
            if (got_p[i] !== 1'b0)
                $display("FAIL left_stop edge %0d: pressed %b required 0", i, got_p[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            KEY1 = (i < 8) ? 1'b0 : 1'b1;
            KEY3 = (i < 8) ? 1'b0 : 1'b1;
            step();
            got_p[i] = bus.key_pressed;
            got_i[i] = bus.insn_key;
        end
        for (int i = 0; i < 21; i++) begin
            exp = (i == 6 || i == 7);
            checks++;
            if (got_p[i] !== exp)
                $display("FAIL b2b_strobe edge %0d: pressed %b required %b", i, got_p[i], exp);
            else passes++;
        end
        checks++;
        if (got_i[6] !== 32'h3) $display("FAIL b2b_first: got %h required 00000003", got_i[6]);
        else passes++;
        checks++;
        if (got_i[7] !== 32'h1) $display("FAIL b2b_second: got %h required 00000001", got_i[7]);
        else passes++;
    endtask

    task automatic test_reset_mid_repeat();
        logic exp;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            KEY2 = 1'b0;
            step();
            exp = (i == 6 || i == 16);
            checks++;
            if (bus.key_pressed !== exp)
                $display("FAIL right_pre edge %0d: pressed %b required %b", i, bus.key_pressed, exp);
            else passes++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.insn_key, bus.key_pressed, bus.key_state} !== 36'h0)
            $display("FAIL async_reset: got %h required 0",
                     {bus.insn_key, bus.key_pressed, bus.key_state});
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.key_pressed !== 1'b0)
                $display("FAIL in_reset cyc %0d: pressed %b required 0", i, bus.key_pressed);
            else passes++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            KEY2 = 1'b0;
            step();
            exp = (i == 6 || i == 16);
            checks++;
            if (bus.key_pressed !== exp)
                $display("FAIL right_post edge %0d: pressed %b required %b", i, bus.key_pressed, exp);
            else passes++;
            if (exp) begin
                checks++;
                if (bus.insn_key !== 32'h2)
                    $display("FAIL right_insn edge %0d: got %h required 00000002", i, bus.insn_key);
                else passes++;
            end
        end
        KEY2 = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_bounce();
        int n_strobe;
        int at;
        do_reset();
        n_strobe = 0;
        at = -1;
        for (int i = 0; i < 30; i++) begin
            if (i < 12) KEY2 = i[0];
            else KEY2 = (i < 20) ? 1'b0 : 1'b1;
            step();
            if (bus.key_pressed === 1'b1) begin
                n_strobe++;
                at = i;
                checks++;
                if (bus.insn_key !== 32'h2)
                    $display("FAIL bounce_insn: got %h required 00000002", bus.insn_key);
                else passes++;
            end
        end
        checks++;
        if (n_strobe !== 1) $display("FAIL bounce_count: got %0d required 1", n_strobe);
        else passes++;
        checks++;
        if (at !== 18) $display("FAIL bounce_latency: got edge %0d required 18", at);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fire_single();
        test_left_repeat();
        test_back_to_back();
        test_reset_mid_repeat();
        test_bounce();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
